// File: rtl/fight_pkg.sv
// Shared encodings for the fight controller and the scene renderer that consumes them.
package fight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MENU     = 3'd1,
    ST_CHOOSE   = 3'd2,
    ST_ANIM_P1  = 3'd3,
    ST_ANIM_P2  = 3'd4,
    ST_HPRED_P1 = 3'd5,
    ST_HPRED_P2 = 3'd6,
    ST_END      = 3'd7
  } fight_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_e;

  localparam logic [3:0] OPT_1 = 4'd1;
  localparam logic [3:0] OPT_2 = 4'd2;
  localparam logic [3:0] OPT_3 = 4'd3;
  localparam logic [3:0] OPT_4 = 4'd4;

  localparam int HP_MAX_DEFAULT = 200;

  // 2x2 grid move (1 2 / 3 4), no wrap; only the highest-priority direction acts.
  function automatic logic [3:0] nav_option(input logic [3:0] opt, input logic up,
                                            input logic down, input logic left,
                                            input logic right);
    logic [3:0] r;
    r = opt;
    if (up) begin
      if (opt == OPT_3) r = OPT_1;
      else if (opt == OPT_4) r = OPT_2;
    end else if (down) begin
      if (opt == OPT_1) r = OPT_3;
      else if (opt == OPT_2) r = OPT_4;
    end else if (left) begin
      if (opt == OPT_2) r = OPT_1;
      else if (opt == OPT_4) r = OPT_3;
    end else if (right) begin
      if (opt == OPT_1) r = OPT_2;
      else if (opt == OPT_3) r = OPT_4;
    end
    return r;
  endfunction

endpackage

// File: rtl/fight_if.sv
// Bundle between the button/frame front end, the fight controller and the scene mux.
interface fight_if;
  // Every input is a one-cycle pulse sampled on the rising clk edge; there is no
  // valid/ready back-pressure, and every output is registered level state.
  logic       frame_tick;
  logic       start;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_confirm;
  logic       btn_back;
  logic [5:0] fight_state;
  logic [3:0] option_state;
  logic [7:0] p1_cur_hp;
  logic [7:0] p2_cur_hp;
  logic       fight_over;
  logic [1:0] winner;

  modport master (
    output frame_tick, start, btn_up, btn_down, btn_left, btn_right, btn_confirm, btn_back,
    input  fight_state, option_state, p1_cur_hp, p2_cur_hp, fight_over, winner
  );

  modport slave (
    input  frame_tick, start, btn_up, btn_down, btn_left, btn_right, btn_confirm, btn_back,
    output fight_state, option_state, p1_cur_hp, p2_cur_hp, fight_over, winner
  );
endinterface

// File: rtl/fight_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) for the opponent's skill pick.
module fight_lfsr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  output logic [7:0] out
);
  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk) begin
    if (!rst_n) r_lfsr <= seed;
    else        r_lfsr <= {r_lfsr[6:0], w_fb};
  end

  assign out = r_lfsr;
endmodule

// File: rtl/fight_controller.sv
// Battle sequencer: menu, skill choice, attack animations and per-frame HP drain for both players.
module fight_controller
  import fight_pkg::*;
#(
  parameter int         HP_MAX     = HP_MAX_DEFAULT,
  parameter int         ANIM_TICKS = 60,
  parameter int         DMG_1      = 20,
  parameter int         DMG_2      = 35,
  parameter int         DMG_3      = 50,
  parameter int         DMG_4      = 10,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input logic    clk,
  input logic    rst_n,
  fight_if.slave bus
);
  localparam int            TW        = ($clog2(ANIM_TICKS + 1) > 6) ? $clog2(ANIM_TICKS + 1) : 6;
  localparam logic [TW-1:0] TICK_LAST = TW'(ANIM_TICKS - 1);
  localparam logic [7:0]    HP_FULL   = 8'(HP_MAX);

  fight_state_e  r_state, w_state_nxt;
  winner_e       r_winner, w_winner_nxt;
  logic [3:0]    r_option, w_option_nxt;
  logic [7:0]    r_hp1, w_hp1_nxt, r_hp2, w_hp2_nxt;
  logic [7:0]    r_dmg, w_dmg_nxt;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic [2:0]    r_skill_p1, w_skill_p1_nxt, r_skill_p2, w_skill_p2_nxt;
  logic          r_fight_over;
  logic [7:0]    w_lfsr;
  logic [3:0]    w_nav;
  logic          w_unused_lfsr;

  fight_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .out   (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[7:2];
  assign w_nav = nav_option(r_option, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right);

  function automatic logic [7:0] dmg_of(input logic [2:0] skill);
    case (skill)
      3'd1:    return 8'(DMG_1);
      3'd2:    return 8'(DMG_2);
      3'd3:    return 8'(DMG_3);
      3'd4:    return 8'(DMG_4);
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_winner_nxt   = r_winner;
    w_option_nxt   = r_option;
    w_hp1_nxt      = r_hp1;
    w_hp2_nxt      = r_hp2;
    w_dmg_nxt      = r_dmg;
    w_tick_nxt     = r_tick;
    w_skill_p1_nxt = r_skill_p1;
    w_skill_p2_nxt = r_skill_p2;
    case (r_state)
      ST_IDLE, ST_END: begin
        if (bus.start) begin
          w_state_nxt  = ST_MENU;
          w_option_nxt = OPT_1;
          w_hp1_nxt    = HP_FULL;
          w_hp2_nxt    = HP_FULL;
          w_winner_nxt = WIN_NONE;
        end
      end
      ST_MENU: begin
        if (bus.btn_confirm) begin
          if (r_option == OPT_1) begin
            w_state_nxt  = ST_CHOOSE;
            w_option_nxt = OPT_1;
          end else if (r_option == OPT_4) begin
            w_state_nxt  = ST_END;
            w_winner_nxt = WIN_NONE;
          end
        end else if (!bus.btn_back) begin
          w_option_nxt = w_nav;
        end
      end
      ST_CHOOSE: begin
        if (bus.btn_confirm) begin
          w_skill_p1_nxt = r_option[2:0];
          w_tick_nxt     = '0;
          w_state_nxt    = ST_ANIM_P1;
        end else if (bus.btn_back) begin
          w_state_nxt  = ST_MENU;
          w_option_nxt = OPT_1;
        end else begin
          w_option_nxt = w_nav;
        end
      end
      ST_ANIM_P1, ST_ANIM_P2: begin
        if (bus.frame_tick) begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt = '0;
            if (r_state == ST_ANIM_P1) begin
              w_dmg_nxt   = dmg_of(r_skill_p1);
              w_state_nxt = ST_HPRED_P2;
            end else begin
              w_dmg_nxt   = dmg_of(r_skill_p2);
              w_state_nxt = ST_HPRED_P1;
            end
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
      end
      // Exit is decided on the post-decrement values of the same tick.
      ST_HPRED_P2: begin
        if (bus.frame_tick) begin
          if (r_dmg != 8'd0 && r_hp2 != 8'd0) begin
            w_dmg_nxt = r_dmg - 8'd1;
            w_hp2_nxt = r_hp2 - 8'd1;
          end
          if (w_hp2_nxt == 8'd0) begin
            w_state_nxt  = ST_END;
            w_winner_nxt = WIN_P1;
          end else if (w_dmg_nxt == 8'd0) begin
            w_skill_p2_nxt = {1'b0, w_lfsr[1:0]} + 3'd1;
            w_tick_nxt     = '0;
            w_state_nxt    = ST_ANIM_P2;
          end
        end
      end
      ST_HPRED_P1: begin
        if (bus.frame_tick) begin
          if (r_dmg != 8'd0 && r_hp1 != 8'd0) begin
            w_dmg_nxt = r_dmg - 8'd1;
            w_hp1_nxt = r_hp1 - 8'd1;
          end
          if (w_hp1_nxt == 8'd0) begin
            w_state_nxt  = ST_END;
            w_winner_nxt = WIN_P2;
          end else if (w_dmg_nxt == 8'd0) begin
            w_state_nxt  = ST_MENU;
            w_option_nxt = OPT_1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_winner     <= WIN_NONE;
      r_option     <= OPT_1;
      r_hp1        <= 8'd0;
      r_hp2        <= 8'd0;
      r_dmg        <= 8'd0;
      r_tick       <= '0;
      r_skill_p1   <= 3'd0;
      r_skill_p2   <= 3'd0;
      r_fight_over <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_winner     <= w_winner_nxt;
      r_option     <= w_option_nxt;
      r_hp1        <= w_hp1_nxt;
      r_hp2        <= w_hp2_nxt;
      r_dmg        <= w_dmg_nxt;
      r_tick       <= w_tick_nxt;
      r_skill_p1   <= w_skill_p1_nxt;
      r_skill_p2   <= w_skill_p2_nxt;
      r_fight_over <= (w_state_nxt == ST_END);
    end
  end

  assign bus.fight_state  = {3'b000, r_state};
  assign bus.option_state = r_option;
  assign bus.p1_cur_hp    = r_hp1;
  assign bus.p2_cur_hp    = r_hp2;
  assign bus.fight_over   = r_fight_over;
  assign bus.winner       = r_winner;
endmodule

// File: tb/tb_fight_controller.sv
// Directed bench for fight_controller: navigation table plus full-fight, run and reset sequences.
module tb_fight_controller;
  localparam logic [6:0] B_NONE  = 7'b0000000;
  localparam logic [6:0] B_START = 7'b1000000;
  localparam logic [6:0] B_CONF  = 7'b0100000;
  localparam logic [6:0] B_BACK  = 7'b0010000;
  localparam logic [6:0] B_UP    = 7'b0001000;
  localparam logic [6:0] B_DOWN  = 7'b0000100;
  localparam logic [6:0] B_LEFT  = 7'b0000010;
  localparam logic [6:0] B_RIGHT = 7'b0000001;

  typedef struct {
    string      name;
    logic [6:0] btns;
    logic [5:0] exp_state;
    logic [3:0] exp_opt;
    logic [7:0] exp_hp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  fight_if     bus ();

  int          n_checks;
  int          n_fail;
  int          exp_hp1;
  int          exp_hp2;
  int          exp_sk2;
  bit          done;
  logic [7:0]  m_lfsr;
  logic [7:0]  last_snap;
  vec_t        vecs[$];
  logic [17:0] exp_q[$];

  fight_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // opponent-skill reference: x^8+x^6+x^5+x^4+1, seed A5, steps every clock
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int dmg_tb(input int s);
    case (s)
      1:       return 20;
      2:       return 35;
      3:       return 50;
      4:       return 10;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic pulse(input logic [6:0] b);
    @(negedge clk);
    {bus.start, bus.btn_confirm, bus.btn_back, bus.btn_up, bus.btn_down, bus.btn_left,
     bus.btn_right} = b;
    @(negedge clk);
    {bus.start, bus.btn_confirm, bus.btn_back, bus.btn_up, bus.btn_down, bus.btn_left,
     bus.btn_right} = B_NONE;
  endtask

  task automatic do_tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    last_snap = m_lfsr;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic add_vec(input string n, input logic [6:0] b, input logic [5:0] st,
                         input logic [3:0] op, input logic [7:0] hp);
    vec_t v;
    v.name = n;
    v.btns = b;
    v.exp_state = st;
    v.exp_opt = op;
    v.exp_hp = hp;
    vecs.push_back(v);
  endtask

  task automatic anim(input int st_during, input int st_after, input string tag);
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      if (i == 59) check({tag, "_anim_hold"}, bus.fight_state, st_during);
    end
    check({tag, "_anim_done"}, bus.fight_state, st_after);
  endtask

  task automatic start_round(input int s);
    pulse(B_CONF);
    check("round_choose_state", bus.fight_state, 2);
    check("round_choose_opt", bus.option_state, 1);
    case (s)
      2: pulse(B_RIGHT);
      3: pulse(B_DOWN);
      4: begin pulse(B_DOWN); pulse(B_RIGHT); end
      default: ;
    endcase
    check("round_skill_opt", bus.option_state, s);
    pulse(B_CONF);
    check("round_anim_state", bus.fight_state, 3);
  endtask

  task automatic p1_attack(input int s);
    int n;
    anim(3, 6, "p1");
    check("p1_anim_hp2", bus.p2_cur_hp, exp_hp2);
    n = (dmg_tb(s) < exp_hp2) ? dmg_tb(s) : exp_hp2;
    for (int i = 1; i <= n; i++) begin
      do_tick();
      if (i == n - 1) check("p2_drain_mid", bus.fight_state, 6);
    end
    exp_hp2 -= n;
    check("p2_hp_after", bus.p2_cur_hp, exp_hp2);
    if (exp_hp2 == 0) begin
      check("ko_p2_state", bus.fight_state, 7);
      check("ko_p2_winner", bus.winner, 1);
      check("ko_p2_over", bus.fight_over, 1);
      done = 1'b1;
    end else begin
      exp_sk2 = int'(last_snap[1:0]) + 1;
      check("p2_drain_exit", bus.fight_state, 4);
    end
  endtask

  task automatic p2_attack();
    int n;
    anim(4, 5, "p2");
    check("p2_anim_hp1", bus.p1_cur_hp, exp_hp1);
    n = (dmg_tb(exp_sk2) < exp_hp1) ? dmg_tb(exp_sk2) : exp_hp1;
    for (int i = 1; i <= n; i++) do_tick();
    exp_hp1 -= n;
    check("p1_hp_after", bus.p1_cur_hp, exp_hp1);
    if (exp_hp1 == 0) begin
      check("ko_p1_state", bus.fight_state, 7);
      check("ko_p1_winner", bus.winner, 2);
      check("ko_p1_over", bus.fight_over, 1);
      done = 1'b1;
    end else begin
      check("p1_drain_exit", bus.fight_state, 1);
      check("p1_drain_opt", bus.option_state, 1);
    end
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    summary();
    $finish;
  end

  initial begin
    logic [17:0] e;
    n_checks = 0;
    n_fail = 0;
    done = 1'b0;
    rst_n = 1'b0;
    bus.frame_tick = 1'b0;
    {bus.start, bus.btn_confirm, bus.btn_back, bus.btn_up, bus.btn_down, bus.btn_left,
     bus.btn_right} = B_NONE;
    repeat (3) @(negedge clk);
    check("rst_state", bus.fight_state, 0);
    check("rst_opt", bus.option_state, 1);
    check("rst_hp1", bus.p1_cur_hp, 0);
    check("rst_hp2", bus.p2_cur_hp, 0);
    check("rst_over", bus.fight_over, 0);
    check("rst_winner", bus.winner, 0);
    rst_n = 1'b1;

    add_vec("idle_right",        B_RIGHT,         6'd0, 4'd1, 8'd0);
    add_vec("start",             B_START,         6'd1, 4'd1, 8'd200);
    add_vec("left_nowrap",       B_LEFT,          6'd1, 4'd1, 8'd200);
    add_vec("right_1_2",         B_RIGHT,         6'd1, 4'd2, 8'd200);
    add_vec("confirm_opt2",      B_CONF,          6'd1, 4'd2, 8'd200);
    add_vec("down_2_4",          B_DOWN,          6'd1, 4'd4, 8'd200);
    add_vec("down_nowrap",       B_DOWN,          6'd1, 4'd4, 8'd200);
    add_vec("left_4_3",          B_LEFT,          6'd1, 4'd3, 8'd200);
    add_vec("up_3_1",            B_UP,            6'd1, 4'd1, 8'd200);
    add_vec("menu_confirm",      B_CONF,          6'd2, 4'd1, 8'd200);
    add_vec("skill_back",        B_BACK,          6'd1, 4'd1, 8'd200);
    add_vec("menu_confirm2",     B_CONF,          6'd2, 4'd1, 8'd200);
    add_vec("skill_down",        B_DOWN,          6'd2, 4'd3, 8'd200);
    add_vec("skill_right",       B_RIGHT,         6'd2, 4'd4, 8'd200);
    add_vec("start_ignored",     B_START,         6'd2, 4'd4, 8'd200);
    add_vec("up_over_left",      B_UP | B_LEFT,   6'd2, 4'd2, 8'd200);
    add_vec("skill_down2",       B_DOWN,          6'd2, 4'd4, 8'd200);
    add_vec("confirm_over_down", B_CONF | B_DOWN, 6'd3, 4'd4, 8'd200);

    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].exp_state, vecs[i].exp_opt, vecs[i].exp_hp});
      pulse(vecs[i].btns);
      e = exp_q.pop_front();
      check({vecs[i].name, "_state"}, bus.fight_state, int'(e[17:12]));
      check({vecs[i].name, "_opt"}, bus.option_state, int'(e[11:8]));
      check({vecs[i].name, "_hp1"}, bus.p1_cur_hp, int'(e[7:0]));
      check({vecs[i].name, "_hp2"}, bus.p2_cur_hp, int'(e[7:0]));
    end

    // full fight: skill 4 first, then skill 3 until someone drops
    exp_hp1 = 200;
    exp_hp2 = 200;
    p1_attack(4);
    if (!done) p2_attack();
    for (int r = 0; r < 8 && !done; r++) begin
      start_round(3);
      p1_attack(3);
      if (!done) p2_attack();
    end

    pulse(B_START);
    check("restart_state", bus.fight_state, 1);
    check("restart_opt", bus.option_state, 1);
    check("restart_hp1", bus.p1_cur_hp, 200);
    check("restart_hp2", bus.p2_cur_hp, 200);
    check("restart_over", bus.fight_over, 0);
    check("restart_winner", bus.winner, 0);

    pulse(B_DOWN);
    pulse(B_RIGHT);
    check("run_opt", bus.option_state, 4);
    pulse(B_CONF);
    check("run_state", bus.fight_state, 7);
    check("run_winner", bus.winner, 0);
    check("run_over", bus.fight_over, 1);
    pulse(B_START);
    check("run_restart_state", bus.fight_state, 1);

    // reset in the middle of p1's HP drain
    exp_hp1 = 200;
    exp_hp2 = 200;
    done = 1'b0;
    start_round(1);
    p1_attack(1);
    anim(4, 5, "rst");
    do_tick();
    do_tick();
    check("mid_drain_state", bus.fight_state, 5);
    check("mid_drain_hp1", bus.p1_cur_hp, 198);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_state", bus.fight_state, 0);
    check("mid_rst_opt", bus.option_state, 1);
    check("mid_rst_hp1", bus.p1_cur_hp, 0);
    check("mid_rst_hp2", bus.p2_cur_hp, 0);
    check("mid_rst_over", bus.fight_over, 0);
    check("mid_rst_winner", bus.winner, 0);
    rst_n = 1'b1;

    summary();
    $finish;
  end
endmodule

// File: doc/fight_controller.md
# fight_controller

Sequential controller that generates the battle state consumed by the fight-scene renderer: `fight_state`, `option_state`, and both players' current HP. It takes debounced one-cycle button pulses and a per-frame tick, runs the menu, skill selection, attack-animation and HP-drain sequence, and picks the opponent's skill pseudo-randomly. It sits between the keyboard/button front end and the VGA scene mux.

## Interface
- `HP_MAX`, 200: HP loaded into both players at fight start; also the maximum HP-bar width in pixels.
- `ANIM_TICKS`, 60: frame ticks spent in each attack-animation state.
- `DMG_1`..`DMG_4`, 20 / 35 / 50 / 10: damage for skills 1..4.
- `LFSR_SEED`, 8'hA5: non-zero seed for the opponent-skill LFSR.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `frame_tick` in 1: one-cycle pulse once per VGA frame.
- `start` in 1: one-cycle pulse that begins a fight.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_confirm`, `btn_back` in 1 each: one-cycle debounced pulses.
- `fight_state` out 6: 0 idle, 1 menu, 2 choosing_skill, 3 anim_p1, 4 anim_p2, 5 hpReducing_p1, 6 hpReducing_p2, 7 end.
- `option_state` out 4: highlighted option, 1..4, laid out as a 2x2 grid (1 2 / 3 4).
- `p1_cur_hp`, `p2_cur_hp` out 8 each: current HP.
- `fight_over` out 1: high while in end.
- `winner` out 2: 0 none/run, 1 p1, 2 p2; valid while `fight_over` is high.

## Operation
- **Reset:** `fight_state`=0, `option_state`=1, both HP=0, `fight_over`=0, `winner`=0. Tick counter, damage counter and latched skills clear; LFSR loads `LFSR_SEED`.
- **idle, `start`:** both HP set to `HP_MAX`, `option_state`=1, go to menu.
- **end, `start`:** same restart as from idle; `fight_over` clears. `start` in every other state is ignored.
- **Navigation** (menu and choosing_skill only):
  - right: 1→2, 3→4. left: 2→1, 4→3. down: 1→3, 2→4. up: 3→1, 4→2. No wrap; any other move leaves the option unchanged.
  - Buttons in all other states are ignored.
  - If several pulses arrive in one cycle, only the highest-priority one acts: confirm > back > up > down > left > right.
- **menu, confirm:**
  - option 1 → choosing_skill, `option_state`=1.
  - option 4 (run) → end, `winner`=0.
  - options 2 and 3 do nothing.
- **choosing_skill:**
  - confirm: latch `skill_p1`=`option_state`, clear the tick counter, go to anim_p1.
  - back: go to menu, `option_state`=1.
- **anim_p1:** count `frame_tick`. On the `ANIM_TICKS`-th tick, load the damage counter with `DMG[skill_p1]` and go to hpReducing_p2.
- **hpReducing_p2:** each `frame_tick`, if the damage counter ≠ 0 and `p2_cur_hp` ≠ 0, decrement both by 1. When either reaches 0:
  - `p2_cur_hp`==0 → end, `winner`=1.
  - otherwise latch `skill_p2` = LFSR[1:0]+1 and go to anim_p2.
- **anim_p2 / hpReducing_p1:** mirror of the above, using `skill_p2` and `p1_cur_hp`.
  - `p1_cur_hp`==0 → end, `winner`=2.
  - otherwise → menu, `option_state`=1.
- **Arithmetic:** damage greater than remaining HP saturates HP at 0, never wraps. HP never exceeds `HP_MAX`.
- **LFSR:** 8-bit, taps x^8+x^6+x^5+x^4+1, advances every clock. All-zero state is unreachable from a non-zero seed.

## Timing
- All outputs are registered. A state or option change is visible one cycle after the triggering pulse or tick.
- anim_p1 / anim_p2 last exactly `ANIM_TICKS` `frame_tick`s.
- An HP drain of D points takes D ticks, or fewer if HP hits 0 first.
- The zero check happens in the same cycle as the tick that makes HP or damage reach 0, so the exit transition follows one cycle later.
- Damage of 0 (a parameter set to 0): exit on the first tick after entering the drain state.
- A `frame_tick` coinciding with a button pulse is handled independently; buttons are ignored in the tick-driven states.
- `rst_n` low in any state (mid-animation, mid-drain) returns all outputs to their reset values on the next edge.

## Structure
- **Package `fight_pkg`:**
  - state codes 0..7, shared with the scene renderer;
  - option codes 1..4;
  - winner codes;
  - default `HP_MAX`.
- **Sub-module `fight_lfsr`:** (clk, rst_n, seed, out[7:0]).
- The rest lives in the one FSM module: next-state logic, tick counter (≥6 bits), damage counter (8 bits), navigation logic.

## Test plan
- Reset then `start` → state 1, option 1, both HP=200.
- Menu, press right, down, down, left → option 1→2→4→4→3. Then up → option 1.
- Menu confirm (option 1) → state 2. Press down, right → option 4. Confirm → state 3 for 60 ticks, then state 6; `p2_cur_hp` falls 200→190 over 10 ticks, then state 4.
- `p2_cur_hp` forced low via repeated skill-3 rounds → HP saturates at 0 (no wrap) → state 7, `fight_over`=1, `winner`=1. A subsequent `start` restarts with HP=200.
- Menu option 4 confirm → state 7, `winner`=0. `btn_back` in state 2 → state 1, option 1.
- `rst_n`=0 during state 5 → next cycle state 0, HP=0, option 1.
- Same-cycle confirm+down in state 2 → confirm wins.
